// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: FSM encodings and default ID/EX bundle layout.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Default ID/EX bundle layout: {rd1, rd2, imm, rs1, rs2, rd, ctrl}
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned REG_ID_W = 4;
  localparam int unsigned CTRL_W   = 1;
  localparam int unsigned DEF_DATA_W = 3 * WORD_W + 3 * REG_ID_W + CTRL_W;

  localparam int unsigned OFS_CTRL = 0;
  localparam int unsigned OFS_RD   = OFS_CTRL + CTRL_W;
  localparam int unsigned OFS_RS2  = OFS_RD + REG_ID_W;
  localparam int unsigned OFS_RS1  = OFS_RS2 + REG_ID_W;
  localparam int unsigned OFS_IMM  = OFS_RS1 + REG_ID_W;
  localparam int unsigned OFS_RD2  = OFS_IMM + WORD_W;
  localparam int unsigned OFS_RD1  = OFS_RD2 + WORD_W;

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage slot of the stage: data register plus valid bit, clearing back to the bubble value.
module pipe_skid_entry #(
  parameter int unsigned       DATA_W  = 61,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wen,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  // Clear beats write so a flush always leaves a clean bubble.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q     <= NOP_VAL;
      valid <= 1'b0;
    end else if (wen) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a 2-entry skid buffer, flush-to-bubble and a saturating stall counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned       DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat moves on a side only in a cycle where its valid and ready are both high;
  // valid never depends on ready, and every output here comes straight from a register.

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q, main_d;
  logic              main_v, skid_v;
  logic              main_wen, main_clr, skid_wen, skid_clr;
  logic              acc, con;
  logic [CNT_W-1:0]  stall_q;

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occupancy = 2'(main_v) + 2'(skid_v);
  assign stall_cnt = stall_q;
  assign dbg_state = state_q;

  assign acc = in_valid & in_ready;
  assign con = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    main_d   = in_data;
    main_wen = 1'b0;
    main_clr = 1'b0;
    skid_wen = 1'b0;
    skid_clr = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_wen = 1'b1;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && con) begin
            main_wen = 1'b1;
          end else if (acc) begin
            skid_wen = 1'b1;
            state_d  = ST_TWO;
          end else if (con) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Skid drains into main so the older entry always leaves first.
          if (con) begin
            main_d   = skid_q;
            main_wen = 1'b1;
            skid_clr = 1'b1;
            state_d  = ST_ONE;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_skid_entry #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr   (main_clr),
    .wen   (main_wen),
    .d     (main_d),
    .q     (main_q),
    .valid (main_v)
  );

  pipe_skid_entry #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr   (skid_clr),
    .wen   (skid_wen),
    .d     (in_data),
    .q     (skid_q),
    .valid (skid_v)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed streams, backpressure, flush, counter saturation and random traffic.
module tb_pipe_stage_skid;

  localparam int unsigned   DW  = 61;
  localparam logic [DW-1:0] NOP = '0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy, dbg_state;
  logic [15:0]   stall_cnt;

  logic          in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [DW-1:0] in_data2 = '0;
  logic          in_ready2, out_valid2;
  logic [DW-1:0] out_data2;
  logic [1:0]    occupancy2, dbg_state2;
  logic [3:0]    stall_cnt2;

  pipe_stage_skid #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  pipe_stage_skid #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2), .dbg_state(dbg_state2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];
  logic [15:0]   exp_cnt = '0;
  bit            model_ok = 1'b0;

  always @(negedge clk) begin
    logic          ev, con, acc;
    logic [DW-1:0] ed;
    ev = (exp_q.size() != 0);
    ed = ev ? exp_q[0] : NOP;
    if (model_ok) begin
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_data", 64'(out_data), 64'(ed));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() != 2));
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("dbg_state", 64'(dbg_state), 64'(exp_q.size()));
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    end
    if (rst) begin
      exp_q.delete();
      exp_cnt  = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      con = ev & out_ready;
      acc = in_valid & (exp_q.size() < 2);
      if (ev && !out_ready && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (con) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(in_data);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    logic [63:0]   r;
    logic [DW-1:0] a_v, b_v, c_v;
    a_v = 61'h0A0A; b_v = 61'h0B0B; c_v = 61'h0C0C;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Preload two entries under backpressure, then reset with an offer pending.
    step(1'b1, 61'h11, 1'b0, 1'b0);
    step(1'b1, 61'h22, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b1; in_data = 61'h33;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'(NOP));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);

    // Back-to-back stream with one cycle of lag.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      if (i >= 2) chk("stream_lag", 64'(out_data), 64'(i - 1));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_last", 64'(out_data), 64'd8);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure: A held, B in skid, C refused until space frees.
    step(1'b1, a_v, 1'b0, 1'b0);
    step(1'b1, b_v, 1'b0, 1'b0);
    step(1'b1, c_v, 1'b0, 1'b0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_occupancy", 64'(occupancy), 64'd2);
    chk("bp_head", 64'(out_data), 64'(a_v));
    step(1'b1, c_v, 1'b0, 1'b0);
    step(1'b1, c_v, 1'b1, 1'b0);
    chk("bp_out_a", 64'(out_data), 64'(a_v));
    step(1'b1, c_v, 1'b1, 1'b0);
    chk("bp_out_b", 64'(out_data), 64'(b_v));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_out_c", 64'(out_data), 64'(c_v));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);
    chk("bp_empty", 64'(occupancy), 64'd0);

    // Flush while full with a new offer pending.
    step(1'b1, 61'h0D0D, 1'b0, 1'b0);
    step(1'b1, 61'h0E0E, 1'b0, 1'b0);
    step(1'b1, 61'h0F0F, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_data", 64'(out_data), 64'(NOP));
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_stall_cnt", 64'(stall_cnt), 64'd5);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_no_ghost", 64'(out_valid), 64'd0);

    // Saturation on the 4-bit counter instance.
    @(posedge clk);
    #1 in_valid2 = 1'b1; in_data2 = 61'h55; out_ready2 = 1'b0;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("sat_mid", 64'(stall_cnt2), 64'd7);
    repeat (17) @(posedge clk);
    #1;
    chk("sat_cap", 64'(stall_cnt2), 64'd15);
    chk("sat_hold_data", 64'(out_data2), 64'h55);
    chk("sat_hold_valid", 64'(out_valid2), 64'd1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), r[DW-1:0],
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
